div_sweep_sched: RTL and testbench

Sequencer that drives the on-chip programmable clock divider through a stored list of frequency steps. Each step holds an 8-bit frequency code and a dwell count measured in divider output toggles. The block translates each code to a 26-bit terminal count and loads it into the divider with a load/ack handshake. It then waits the programmed number of toggles before advancing, either once through the list or looping.

---
 rtl/div_sweep_pkg.sv | 39 +++
 rtl/div_code_lut.sv | 12 +
 rtl/div_sweep_sched.sv | 114 +++++++++++
 tb/tb_div_sweep_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sweep_pkg.sv
// Shared state encoding and the frequency-code decode table for the divider sweep sequencer.
// code_to_div is the single source of the table; the divider reuses it through div_code_lut.
package div_sweep_pkg;

    localparam int CODE_W = 8;
    localparam int LUT_W  = 26;

    localparam logic [LUT_W-1:0] DIV_DEFAULT = 26'd59_999_999;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD,
        DWELL,
        NEXT,
        DONE
    } state_t;

    function automatic logic [LUT_W-1:0] code_to_div(input logic [CODE_W-1:0] code);
        logic [LUT_W-1:0] div;
        case (code)
            8'd1:    div = 26'd59_999_999;
            8'd2:    div = 26'd29_999_999;
            8'd10:   div = 26'd599_999;
            8'd100:  div = 26'd59_999;
            8'd206:  div = 26'd59_999;
            8'd213:  div = 26'd5_999;
            8'd220:  div = 26'd599;
            8'd227:  div = 26'd59;
            8'd230:  div = 26'd14;
            8'd233:  div = 26'd5;
            8'd234:  div = 26'd2;
            8'd235:  div = 26'd1;
            default: div = DIV_DEFAULT;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/div_code_lut.sv
// Combinational frequency-code to terminal-count decoder.
// Kept as its own module so the divider can instantiate the identical table.
module div_code_lut
    import div_sweep_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [LUT_W-1:0]  div
);

    assign div = code_to_div(code);

endmodule

// File: rtl/div_sweep_sched.sv
// Steps the programmable clock divider through a stored list of (code, dwell) entries,
// loading each terminal count with a load/ack handshake and dwelling for a number of toggles.
module div_sweep_sched
    import div_sweep_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter int  DIV_W   = 26,
    parameter int  DWELL_W = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [CODE_W-1:0]  cfg_code,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [LW-1:0]      len,
    input  logic               div_tick,
    input  logic               div_ack,
    output logic [DIV_W-1:0]   div_value,
    output logic               div_load,
    output logic               busy,
    output logic [AW-1:0]      step_idx,
    output logic               done
);

    state_t             state, state_nxt;
    logic [CODE_W-1:0]  code_mem  [DEPTH];
    logic [DWELL_W-1:0] dwell_mem [DEPTH];
    logic [LW-1:0]      len_q;
    logic               loop_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [CODE_W-1:0]  cur_code;
    logic [DWELL_W-1:0] cur_dwell;
    logic [LUT_W-1:0]   lut_div;
    logic               last_step;

    assign cur_code  = code_mem[step_idx];
    assign cur_dwell = dwell_mem[step_idx];
    assign last_step = {1'b0, step_idx} >= (len_q - LW'(1));

    div_code_lut u_lut (
        .code (cur_code),
        .div  (lut_div)
    );

    // NOTE: the program store is a flop array, not RAM, so rst can clear every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_mem[i]  <= '0;
                dwell_mem[i] <= '0;
            end
        end else if (cfg_we && state == IDLE) begin
            code_mem[cfg_addr]  <= cfg_code;
            dwell_mem[cfg_addr] <= cfg_dwell;
        end
    end

    // NOTE: every clocked register uses non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: state_nxt takes its default first so no branch can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && len != '0) state_nxt = CHECK;
            CHECK:   state_nxt = (cur_dwell == '0) ? NEXT : LOAD;
            LOAD:    if (div_ack) state_nxt = DWELL;
            DWELL:   if (div_tick && dwell_cnt == cur_dwell - DWELL_W'(1)) state_nxt = NEXT;
            NEXT:    state_nxt = (!last_step || loop_q) ? CHECK : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins over start, ack and tick alike.
        if (stop) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            loop_q    <= 1'b0;
            step_idx  <= '0;
            dwell_cnt <= '0;
            div_value <= DIV_W'(DIV_DEFAULT);
        end else begin
            if (state == IDLE && state_nxt == CHECK) begin
                len_q    <= (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                loop_q   <= loop_en;
                step_idx <= '0;
            end
            if (state == NEXT && state_nxt == CHECK)
                step_idx <= last_step ? '0 : step_idx + AW'(1);
            if (state == CHECK && state_nxt == LOAD)
                div_value <= DIV_W'(lut_div);
            if (state == LOAD && state_nxt == DWELL)
                dwell_cnt <= '0;
            else if (state == DWELL && div_tick)
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
    end

    assign div_load = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_div_sweep_sched.sv
// Randomised and directed bench for div_sweep_sched: expected loads and done pulses are
// queued from a list-level model and matched by an independent output monitor.
module tb_div_sweep_sched;

    localparam int DEPTH   = 8;
    localparam int DIV_W   = 26;
    localparam int DWELL_W = 8;
    localparam int AW      = 3;
    localparam int LW      = 4;
    localparam int DEF_DIV = 59_999_999;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [AW-1:0]      cfg_addr = '0;
    logic [7:0]         cfg_code = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               loop_en = 1'b0;
    logic [LW-1:0]      len = '0;
    logic               div_tick = 1'b0;
    logic               div_ack = 1'b0;
    logic [DIV_W-1:0]   div_value;
    logic               div_load;
    logic               busy;
    logic [AW-1:0]      step_idx;
    logic               done;

    div_sweep_sched #(.DEPTH(DEPTH), .DIV_W(DIV_W), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_code  (cfg_code),
        .cfg_dwell (cfg_dwell),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .len       (len),
        .div_tick  (div_tick),
        .div_ack   (div_ack),
        .div_value (div_value),
        .div_load  (div_load),
        .busy      (busy),
        .step_idx  (step_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef enum {EV_LOAD, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       value;
        int       idx;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  m_code  [DEPTH];
    int  m_dwell [DEPTH];
    int  div_of_code [int];
    int  known_codes [12] = '{1, 2, 10, 100, 206, 213, 220, 227, 230, 233, 234, 235};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_div(input int code);
        return div_of_code.exists(code) ? div_of_code[code] : DEF_DIV;
    endfunction

    function automatic void push_ev(input ev_kind_t kind, input int value, input int idx);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.idx   = idx;
        exp_q.push_back(e);
    endfunction

    // Output monitor: every load request and done pulse must match the queue head.
    initial begin
        logic prev_load;
        ev_t  e;
        prev_load = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_load = 1'b0;
            end else begin
                if (div_load && !prev_load) begin
                    if (exp_q.size() == 0) begin
                        check("load_expected", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_is_load", 32'(e.kind), 32'(EV_LOAD));
                        check("load_value", 32'(div_value), e.value);
                        check("load_step_idx", 32'(step_idx), e.idx);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("done_expected", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_is_done", 32'(e.kind), 32'(EV_DONE));
                    end
                end
                prev_load = div_load;
            end
        end
    end

    task automatic write_entry(input int a, input int code, input int dwell, input bit model_upd);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_code  = 8'(code);
        cfg_dwell = DWELL_W'(dwell);
        @(negedge clk);
        cfg_we = 1'b0;
        if (model_upd) begin
            m_code[a]  = code;
            m_dwell[a] = dwell;
        end
    endtask

    task automatic start_seq(input int len_v, input bit loop_v);
        start   = 1'b1;
        len     = LW'(len_v);
        loop_en = loop_v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_load();
        int n;
        n = 0;
        while (!div_load && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("load_seen", 32'(div_load), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy), 0);
    endtask

    // Divider side: hold off ack (optionally with stray ticks), then supply exactly dwell ticks.
    task automatic serve_load(input int dwell, input int exp_val, input int ack_dly, input bit noise);
        int idx;
        wait_load();
        for (int i = 0; i < ack_dly; i++) begin
            div_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("load_held", 32'(div_load), 1);
            check("value_held", 32'(div_value), exp_val);
        end
        div_tick = 1'b0;
        div_ack  = 1'b1;
        @(negedge clk);
        div_ack = 1'b0;
        check("ack_drops_load", 32'(div_load), 0);
        for (int k = 1; k <= dwell; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            div_tick = 1'b1;
            @(negedge clk);
            div_tick = 1'b0;
            if (k < dwell) begin
                idx = int'(step_idx);
                repeat (3) @(negedge clk);
                check("still_dwelling", 32'(busy && !div_load && int'(step_idx) == idx), 1);
            end
        end
    endtask

    task automatic run_once(input int len_v, input int ack_dly, input bit noise);
        int eff;
        int dw[$];
        int vals[$];
        eff = (len_v > DEPTH) ? DEPTH : len_v;
        for (int i = 0; i < eff; i++) begin
            if (m_dwell[i] != 0) begin
                push_ev(EV_LOAD, ref_div(m_code[i]), i);
                dw.push_back(m_dwell[i]);
                vals.push_back(ref_div(m_code[i]));
            end
        end
        if (eff > 0) push_ev(EV_DONE, 0, 0);
        start_seq(len_v, 1'b0);
        if (eff == 0) begin
            @(negedge clk);
            check("len0_ignored", 32'(busy), 0);
        end
        foreach (dw[k]) serve_load(dw[k], vals[k], ack_dly, noise);
        wait_idle();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int code;
        foreach (known_codes[i]) div_of_code[known_codes[i]] = 0;
        div_of_code[1]   = 59_999_999;
        div_of_code[2]   = 29_999_999;
        div_of_code[10]  = 599_999;
        div_of_code[100] = 59_999;
        div_of_code[206] = 59_999;
        div_of_code[213] = 5_999;
        div_of_code[220] = 599;
        div_of_code[227] = 59;
        div_of_code[230] = 14;
        div_of_code[233] = 5;
        div_of_code[234] = 2;
        div_of_code[235] = 1;
        for (int i = 0; i < DEPTH; i++) begin
            m_code[i]  = 0;
            m_dwell[i] = 0;
        end

        // Reset state
        @(negedge clk);
        check("rst_div_value", 32'(div_value), DEF_DIV);
        check("rst_div_load", 32'(div_load), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_step_idx", 32'(step_idx), 0);
        rst = 1'b0;
        @(negedge clk);
        run_once(0, 1, 1'b0);

        // Two-step single pass
        write_entry(0, 227, 3, 1'b1);
        write_entry(1, 235, 2, 1'b1);
        run_once(2, 1, 1'b0);
        check("final_value", 32'(div_value), 1);

        // Looping: indices 0,1,0,1 then abort during the fifth load
        write_entry(0, 227, 5, 1'b1);
        write_entry(1, 235, 5, 1'b1);
        for (int r = 0; r < 2; r++) begin
            push_ev(EV_LOAD, 59, 0);
            push_ev(EV_LOAD, 1, 1);
        end
        push_ev(EV_LOAD, 59, 0);
        start_seq(2, 1'b1);
        for (int r = 0; r < 2; r++) begin
            serve_load(5, 59, 1, 1'b0);
            serve_load(5, 1, 1, 1'b0);
        end
        wait_load();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop_en = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_load", 32'(div_load), 0);
        check("stop_value_hold", 32'(div_value), 59);
        repeat (4) @(negedge clk);
        check("loop_drained", 32'(exp_q.size()), 0);

        // Zero-dwell entry skipped, then unknown code
        write_entry(0, 10, 0, 1'b1);
        write_entry(1, 100, 1, 1'b1);
        run_once(2, 1, 1'b0);
        write_entry(0, 7, 1, 1'b1);
        run_once(1, 2, 1'b0);

        // Ack withheld with stray ticks during LOAD
        write_entry(0, 220, 2, 1'b1);
        run_once(1, 10, 1'b1);

        // Stop coincident with ack
        write_entry(0, 234, 1, 1'b1);
        push_ev(EV_LOAD, 2, 0);
        start_seq(1, 1'b0);
        wait_load();
        stop    = 1'b1;
        div_ack = 1'b1;
        @(negedge clk);
        stop    = 1'b0;
        div_ack = 1'b0;
        check("stop_ack_busy", 32'(busy), 0);
        check("stop_ack_load", 32'(div_load), 0);
        check("stop_ack_value", 32'(div_value), 2);
        repeat (3) @(negedge clk);
        check("stop_ack_no_done", 32'(exp_q.size()), 0);

        // Program write while busy is dropped
        write_entry(0, 213, 2, 1'b1);
        write_entry(1, 220, 1, 1'b1);
        push_ev(EV_LOAD, 5_999, 0);
        push_ev(EV_LOAD, 599, 1);
        push_ev(EV_DONE, 0, 0);
        start_seq(2, 1'b0);
        serve_load(2, 5_999, 1, 1'b0);
        write_entry(1, 1, 9, 1'b0);
        serve_load(1, 599, 1, 1'b0);
        wait_idle();
        check("busy_write_drained", 32'(exp_q.size()), 0);
        run_once(2, 1, 1'b0);

        // Maximum dwell
        write_entry(0, 230, 255, 1'b1);
        run_once(1, 1, 1'b0);

        // Randomised programs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                code = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255))
                                                   : known_codes[$urandom_range(0, 11)];
                write_entry(i, code, int'($urandom_range(0, 3)), 1'b1);
            end
            run_once(int'($urandom_range(0, DEPTH + 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
        end

        // Async reset mid-dwell, then an all-skip pass
        write_entry(0, 227, 4, 1'b1);
        push_ev(EV_LOAD, 59, 0);
        start_seq(1, 1'b0);
        wait_load();
        div_ack = 1'b1;
        @(negedge clk);
        div_ack = 1'b0;
        repeat (2) begin
            div_tick = 1'b1;
            @(negedge clk);
            div_tick = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_div_value", 32'(div_value), DEF_DIV);
        check("arst_busy", 32'(busy), 0);
        check("arst_load", 32'(div_load), 0);
        check("arst_step_idx", 32'(step_idx), 0);
        check("arst_done", 32'(done), 0);
        for (int i = 0; i < DEPTH; i++) begin
            m_code[i]  = 0;
            m_dwell[i] = 0;
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_once(DEPTH, 1, 1'b0);
        check("skip_all_value", 32'(div_value), DEF_DIV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
